bsg_mux2_rr_arb_width_p64: RTL and testbench

Two-requester round-robin arbiter and output register that controls the 2:1 64-bit data select in the backend datapath. Each requester presents a valid/data pair. The block picks one per cycle, steers its data through the 2:1 select, and captures the result into a one-entry output register with a valid/ready handshake toward the consumer. An optional lock lets a requester keep ownership across consecutive multi-beat transfers.

---
 rtl/bsg_mux2_rr_arb_width_p64.sv | 96 +++++++++
 tb/tb_bsg_mux2_rr_arb_width_p64.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bsg_mux2_rr_arb_width_p64.sv
// Two-requester round-robin arbiter feeding a 2:1 data select and a one-entry
// output register with valid/ready toward the consumer; optional ownership lock.
module bsg_mux2_rr_arb_width_p64 #(
   parameter int width_p = 64
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v0_i,
   input  logic [width_p-1:0] data0_i,
   output logic               ready0_o,
   input  logic               v1_i,
   input  logic [width_p-1:0] data1_i,
   output logic               ready1_o,
   input  logic               lock_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   output logic               tag_o,
   input  logic               ready_i
);

   logic               full_q,   full_d;
   logic [width_p-1:0] data_q,   data_d;
   logic               tag_q,    tag_d;
   logic               last_q,   last_d;
   logic               locked_q, locked_d;
   logic               owner_q,  owner_d;

   logic accept;
   logic grant0, grant1;
   logic xfer;

   // Register can take a new beat when empty or being drained this cycle.
   assign accept = ~full_q | ready_i;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (locked_q) begin
         // Non-owner is shut out even while the owner is idle.
         grant0 = v0_i & ~owner_q;
         grant1 = v1_i &  owner_q;
      end else if (v0_i & v1_i) begin
         grant1 = ~last_q;
         grant0 =  last_q;
      end else begin
         grant0 = v0_i;
         grant1 = v1_i;
      end
   end

   assign xfer     = accept & (grant0 | grant1);
   assign ready0_o = accept & grant0 & ~reset_i;
   assign ready1_o = accept & grant1 & ~reset_i;

   always_comb begin
      full_d   = full_q;
      data_d   = data_q;
      tag_d    = tag_q;
      last_d   = last_q;
      locked_d = locked_q;
      owner_d  = owner_q;
      if (xfer) begin
         full_d   = 1'b1;
         data_d   = grant1 ? data1_i : data0_i;
         tag_d    = grant1;
         last_d   = grant1;
         locked_d = lock_i;
         if (lock_i) owner_d = grant1;
      end else if (ready_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         full_q   <= 1'b0;
         data_q   <= '0;
         tag_q    <= 1'b0;
         last_q   <= 1'b1;
         locked_q <= 1'b0;
         owner_q  <= 1'b0;
      end else begin
         full_q   <= full_d;
         data_q   <= data_d;
         tag_q    <= tag_d;
         last_q   <= last_d;
         locked_q <= locked_d;
         owner_q  <= owner_d;
      end
   end

   assign v_o    = full_q;
   assign data_o = data_q;
   assign tag_o  = tag_q;

endmodule

// File: tb/tb_bsg_mux2_rr_arb_width_p64.sv
// Directed bench for the 2-way round-robin arbiter / output register.
module tb_bsg_mux2_rr_arb_width_p64;
   localparam int W = 64;

   logic         clk_i = 1'b0;
   logic         reset_i;
   logic         v0_i, v1_i, lock_i, ready_i;
   logic [W-1:0] data0_i, data1_i;
   logic         ready0_o, ready1_o, v_o, tag_o;
   logic [W-1:0] data_o;

   int total = 0;
   int bad   = 0;

   bsg_mux2_rr_arb_width_p64 #(.width_p(W)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .v0_i(v0_i), .data0_i(data0_i), .ready0_o(ready0_o),
      .v1_i(v1_i), .data1_i(data1_i), .ready1_o(ready1_o),
      .lock_i(lock_i), .v_o(v_o), .data_o(data_o), .tag_o(tag_o),
      .ready_i(ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b1; v0_i = 1'b0; v1_i = 1'b0; lock_i = 1'b0; ready_i = 1'b1;
      data0_i = '0; data1_i = '0;
      step(); step();
      @(negedge clk_i); reset_i = 1'b0;
      step();
      v0_i = 1'b1; data0_i = 64'h77;
      step();
      total++; if (v_o !== 1'b1 || data_o !== 64'h77) begin bad++;
         $display("FAIL pre_reset_fill v_o=%b data_o=%h want 1 77", v_o, data_o); end
      v1_i = 1'b1; data1_i = 64'h88;
      @(negedge clk_i); reset_i = 1'b1; #1;
      total++; if (v_o !== 1'b0 || data_o !== 64'h0 || tag_o !== 1'b0) begin bad++;
         $display("FAIL reset_async_out v_o=%b data_o=%h tag_o=%b want 0 0 0", v_o, data_o, tag_o); end
      total++; if (ready0_o !== 1'b0 || ready1_o !== 1'b0) begin bad++;
         $display("FAIL reset_ready r0=%b r1=%b want 0 0", ready0_o, ready1_o); end
      @(negedge clk_i); reset_i = 1'b0; #1;
      total++; if (ready0_o !== 1'b1 || ready1_o !== 1'b0) begin bad++;
         $display("FAIL reset_first_tie r0=%b r1=%b want 1 0", ready0_o, ready1_o); end
      step();
      total++; if (v_o !== 1'b1 || tag_o !== 1'b0 || data_o !== 64'h77) begin bad++;
         $display("FAIL reset_first_grant v=%b tag=%b data=%h want 1 0 77", v_o, tag_o, data_o); end
      v0_i = 1'b0; v1_i = 1'b0;
      step();
   endtask

   task automatic test_single();
      ready_i = 1'b1; v1_i = 1'b0; v0_i = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         data0_i = 64'(i);
         #1;
         total++; if (ready0_o !== 1'b1 || ready1_o !== 1'b0) begin bad++;
            $display("FAIL single_ready beat%0d r0=%b r1=%b want 1 0", i, ready0_o, ready1_o); end
         step();
         total++; if (v_o !== 1'b1 || tag_o !== 1'b0 || data_o !== 64'(i)) begin bad++;
            $display("FAIL single_out beat%0d v=%b tag=%b data=%h want 1 0 %h", i, v_o, tag_o, data_o, i); end
      end
      v0_i = 1'b0;
      step();
      total++; if (v_o !== 1'b0) begin bad++;
         $display("FAIL single_drain v_o=%b want 0", v_o); end
   endtask

   task automatic test_alternate();
      logic exp_tag;
      // One lone beat from requester 1 so requester 0 leads the tie sequence.
      ready_i = 1'b1; v1_i = 1'b1; data1_i = 64'h0;
      step();
      v0_i = 1'b1; data0_i = {16{4'hA}}; data1_i = {16{4'h5}};
      for (int i = 0; i < 6; i++) begin
         exp_tag = i[0];
         step();
         total++; if (v_o !== 1'b1 || tag_o !== exp_tag ||
                      data_o !== (exp_tag ? {16{4'h5}} : {16{4'hA}})) begin bad++;
            $display("FAIL alternate beat%0d tag=%b data=%h want tag %b", i, tag_o, data_o, exp_tag); end
      end
      v0_i = 1'b0; v1_i = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      ready_i = 1'b1; v0_i = 1'b0; v1_i = 1'b1; data1_i = 64'hDEAD;
      step();
      ready_i = 1'b0; v0_i = 1'b1; data0_i = 64'hBEEF; data1_i = 64'hCAFE;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (ready0_o !== 1'b0 || ready1_o !== 1'b0) begin bad++;
            $display("FAIL bp_ready cyc%0d r0=%b r1=%b want 0 0", i, ready0_o, ready1_o); end
         step();
         total++; if (v_o !== 1'b1 || tag_o !== 1'b1 || data_o !== 64'hDEAD) begin bad++;
            $display("FAIL bp_hold cyc%0d v=%b tag=%b data=%h want 1 1 dead", i, v_o, tag_o, data_o); end
      end
      ready_i = 1'b1; #1;
      total++; if (ready0_o !== 1'b1 || ready1_o !== 1'b0) begin bad++;
         $display("FAIL bp_release r0=%b r1=%b want 1 0", ready0_o, ready1_o); end
      step();
      total++; if (tag_o !== 1'b0 || data_o !== 64'hBEEF) begin bad++;
         $display("FAIL bp_after tag=%b data=%h want 0 beef", tag_o, data_o); end
      v0_i = 1'b0; v1_i = 1'b0;
      step();
   endtask

   task automatic test_lock();
      logic [2:0] locks;
      locks = 3'b011;
      ready_i = 1'b1; v0_i = 1'b1; v1_i = 1'b1; data0_i = 64'h5000;
      for (int i = 0; i < 3; i++) begin
         lock_i = locks[i]; data1_i = 64'h100 + 64'(i);
         #1;
         total++; if (ready0_o !== 1'b0 || ready1_o !== 1'b1) begin bad++;
            $display("FAIL lock_ready beat%0d r0=%b r1=%b want 0 1", i, ready0_o, ready1_o); end
         step();
         total++; if (tag_o !== 1'b1 || data_o !== 64'h100 + 64'(i)) begin bad++;
            $display("FAIL lock_out beat%0d tag=%b data=%h want 1 %h", i, tag_o, data_o, 64'h100 + i); end
      end
      lock_i = 1'b0; #1;
      total++; if (ready0_o !== 1'b1 || ready1_o !== 1'b0) begin bad++;
         $display("FAIL lock_release r0=%b r1=%b want 1 0", ready0_o, ready1_o); end
      step();
      total++; if (tag_o !== 1'b0 || data_o !== 64'h5000) begin bad++;
         $display("FAIL lock_after tag=%b data=%h want 0 5000", tag_o, data_o); end
   endtask

   task automatic test_reset_mid_lock();
      // last is 0 here, so requester 1 wins and takes the lock.
      ready_i = 1'b1; v0_i = 1'b1; v1_i = 1'b1; lock_i = 1'b1; data1_i = 64'h222;
      step();
      total++; if (tag_o !== 1'b1 || data_o !== 64'h222) begin bad++;
         $display("FAIL rml_locked_beat tag=%b data=%h want 1 222", tag_o, data_o); end
      lock_i = 1'b0;
      @(negedge clk_i); reset_i = 1'b1; #1;
      total++; if (v_o !== 1'b0 || ready0_o !== 1'b0 || ready1_o !== 1'b0) begin bad++;
         $display("FAIL rml_reset v=%b r0=%b r1=%b want 0 0 0", v_o, ready0_o, ready1_o); end
      @(negedge clk_i); reset_i = 1'b0; #1;
      total++; if (ready0_o !== 1'b1 || ready1_o !== 1'b0) begin bad++;
         $display("FAIL rml_unlocked r0=%b r1=%b want 1 0", ready0_o, ready1_o); end
      step();
      total++; if (v_o !== 1'b1 || tag_o !== 1'b0 || data_o !== 64'h5000) begin bad++;
         $display("FAIL rml_after v=%b tag=%b data=%h want 1 0 5000", v_o, tag_o, data_o); end
      v0_i = 1'b0; v1_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_backpressure();
      test_lock();
      test_reset_mid_lock();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
